// File: rtl/uart_client_rx.sv
// UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, mid-bit sampling of a synchronized line.
// Latency: rx_complete fires 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 2 cycles after the rx_in falling edge.
// Backpressure: none; rx_byte/rx_complete/frame_error are strobes the consumer must take on the cycle given.
module uart_client_rx #(
    // Cycles per UART bit; legal range 8..4095 and even, so CLKS_PER_BIT/2 is an exact half bit.
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       sourceClk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       rx_complete,
    output logic       frame_error,
    output logic       busy
);

    // The timer only ever has to hold CLKS_PER_BIT-1, so clog2 of the bit period is wide enough
    // and the counter can never wrap before reaching either compare value.
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        DONE       = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    // Synchronizer stages; reset high so a reset never looks like a start bit.
    logic          rx_meta_q;
    logic          rx_sync_q;

    state_t        state_q;
    state_t        state_d;

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [TW-1:0] timer_inc;
    logic [2:0]    bit_idx_q;
    logic [2:0]    bit_idx_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic [7:0]    rx_byte_q;
    logic [7:0]    rx_byte_d;
    logic          rx_complete_q;
    logic          rx_complete_d;
    logic          frame_error_q;
    logic          frame_error_d;

    assign timer_inc = timer_q + TIMER_ONE;

    // Two-flop synchronizer: rx_in is asynchronous and is never used before rx_sync_q.
    always_ff @(posedge sourceClk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
        end
    end

    // FSM state register.
    always_ff @(posedge sourceClk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath updates: bit timing, shifting, byte capture and strobes.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_byte_d     = rx_byte_q;
        rx_complete_d = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                // rx_en only gates new start detection; a frame already under way always finishes.
                if (rx_en && !rx_sync_q) begin
                    state_d = START;
                    timer_d = '0;
                end
            end

            START: begin
                // Re-check the line half a bit in: still low means a real start bit, high means a glitch.
                if (timer_q == HALF_M1) begin
                    timer_d   = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_sync_q ? IDLE : DATA;
                end else begin
                    timer_d = timer_inc;
                end
            end

            DATA: begin
                // One full bit period after the previous sample lands in the middle of the next bit.
                if (timer_q == FULL_M1) begin
                    timer_d   = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    timer_d = timer_inc;
                end
            end

            STOP: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    if (rx_sync_q) begin
                        state_d = DONE;
                    end else begin
                        // Bad stop bit: flag it once here and park until the line goes idle,
                        // so a held-low break cannot retrigger start detection.
                        frame_error_d = 1'b1;
                        state_d       = BREAK_WAIT;
                    end
                end else begin
                    timer_d = timer_inc;
                end
            end

            DONE: begin
                // rx_byte only ever changes here, so a framing error leaves the old byte intact.
                rx_byte_d     = shift_q;
                rx_complete_d = 1'b1;
                state_d       = IDLE;
            end

            BREAK_WAIT: begin
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers; reset clears everything so an aborted frame leaves nothing behind.
    always_ff @(posedge sourceClk) begin
        if (reset) begin
            timer_q       <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            rx_byte_q     <= 8'h00;
            rx_complete_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_byte_q     <= rx_byte_d;
            rx_complete_q <= rx_complete_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign rx_byte     = rx_byte_q;
    assign rx_complete = rx_complete_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q != IDLE);

endmodule
